// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings and the frame state machine states.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: raises bit_done in the last clk cycle of each bit period.
// Latency: none (bit_done is decoded from the counter); clear restarts the period at the next edge.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_done = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits on a registered tx.
// Latency: start bit one edge after acceptance; in_ready also high in the last stop cycle for gapless streaming.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy
);

    if (CLKS_PER_BIT < 2) begin : g_chk_clks
        $error("uart_tx_core: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_tx_core: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("uart_tx_core: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_tx_core: STOP_BITS must be 1 or 2");
    end

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 bit_done;
    logic                 last_stop;
    logic                 accept;
    logic                 clear;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .bit_done(bit_done)
    );

    assign last_stop = (state_q == ST_STOP) && (stop_cnt_q == STOP_LAST) && bit_done;
    assign in_ready  = (state_q == ST_IDLE) || last_stop;
    assign accept    = in_valid && in_ready;
    // Every bit period starts from a fresh divider count.
    assign clear     = accept || (state_d != state_q);
    assign tx        = tx_q;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        case (state_q)
            ST_IDLE: ;
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Acceptance from the last stop cycle overrides the return to IDLE.
        if (accept) begin
            state_d    = ST_START;
            shift_d    = in_data;
            par_d      = (PARITY == PARITY_EVEN) ? ^in_data : ~^in_data;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
        end
    end

    always_comb begin
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Parametrised UART transmitter: accepts one data word per valid/ready handshake and serialises it onto `tx` as a standard asynchronous frame. The frame is start bit, then DATA_BITS data bits LSB-first, then an optional parity bit, then 1 or 2 stop bits. Bit timing comes from an internal clock-enable divider, so no external baud tick is needed. The block sits between a byte-producing client (FIFO, command engine) and the FPGA pin.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit period (≥2; 868 = 100 MHz / 115200)
- DATA_BITS, 8, data bits per frame (5..9)
- PARITY, 0, 0 = none, 1 = odd, 2 = even (3 illegal)
- STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
- clk  in  1  single clock; everything is synchronous to its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  client presents a word
- in_data  in  DATA_BITS  word to send
- in_ready  out  1  block can accept a word this cycle
- tx  out  1  serial line, idle high, registered
- busy  out  1  a frame is in progress (start bit through last stop bit)

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
  - PARITY is skipped when PARITY = 0.
  - STOP lasts STOP_BITS bit periods.
- Accept: a word is accepted on any clk edge with in_valid && in_ready. At acceptance, in_data is captured into a shift register and the parity bit is computed from it.
  - Even parity bit = ^data.
  - Odd parity bit = ~^data.
- in_ready is high in IDLE. It is also high in the final clk cycle of the final stop bit, so back-to-back frames have zero gap.
- DATA state shifts LSB-first. A bit counter of width $clog2(DATA_BITS+1) counts 0..DATA_BITS-1, and the state exits after bit DATA_BITS-1.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - Reloads to 0 on every state transition and on acceptance.
- tx drives: 0 in START, the current data bit in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
- in_data and in_valid are ignored while in_ready = 0. Changes to in_data after acceptance do not affect the frame.
- If in_valid stays low during the final stop cycle, the block returns to IDLE with tx = 1.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - tx = 1, busy = 0, in_ready = 1
  - state = IDLE, all counters 0, shift register 0
- Reset asserted mid-frame: tx goes high immediately, the word is discarded, and nothing is replayed.
- Latency: acceptance at edge k puts tx = 0 (start bit) from edge k+1.
- busy rises at edge k+1 and stays high through the last stop cycle.
- Each bit on tx is held exactly CLKS_PER_BIT cycles.
- Frame length is F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Continuous streaming (in_valid held high): one word every F cycles, and tx shows no idle cycle between a stop bit and the next start bit.
- Acceptance in the last stop cycle behaves exactly like acceptance from IDLE: the start bit begins at the next edge.

## Structure
- Shared package uart_pkg holds:
  - parity encodings PARITY_NONE/ODD/EVEN
  - the state enum/encoding
- The same package is reused by the future receiver.
- Sub-module uart_baud_gen (parameter CLKS_PER_BIT; inputs clk, rst_n, clear; output bit_done): the divider. It produces bit_done in the last cycle of each bit period.
- The FSM, shift register and parity logic live in uart_tx_core.
- Elaboration-time checks reject CLKS_PER_BIT < 2, DATA_BITS outside 5..9, PARITY = 3, and STOP_BITS outside 1..2.

## Test plan
- CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1; send 0xA5 → tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. busy high for 40 cycles, and in_ready high only in the last of those cycles.
- Same word with PARITY=2 → parity bit 0 after the data bits; with PARITY=1 → parity bit 1. Frame is 44 cycles.
- STOP_BITS=2, in_valid held high with words 0x00 then 0xFF:
  - Each frame is 44 cycles (PARITY=0).
  - Second start bit follows the second stop bit with zero gap.
  - Exactly one acceptance per frame.
- DATA_BITS=5, send 0x1F (in_data=5'h1F) → start, five 1s, stop; 28 cycles at CLKS_PER_BIT=4.
- Assert rst_n=0 during data bit 3 → tx=1 and busy=0 in the same cycle. After release, a new word 0x3C transmits correctly from IDLE.
- Change in_data every cycle after acceptance of 0x81 → the captured frame still carries 0x81.
